register_file: RTL

ARM-style 16 x 32-bit general register file feeding the operand-fetch stage. Accepts a 4-bit write address, converts it to one-hot register load enables, and commits the write on the rising clock edge. Provides three combinational read ports (operands A and B, store data D) and a dedicated program-counter path for R15, updated each cycle by the fetch stage.

---
 rtl/register_file_pkg.sv | 34 +++
 rtl/register_file_if.sv | 36 +++
 rtl/register_file_binary_decoder.sv | 16 +
 rtl/register_file.sv | 99 +++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// register_file shared definitions: sizes, the R15 index,
// the R15 next-value source encoding and its select helper.
package register_file_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_PC = 4'd15;

  typedef enum logic [1:0] {
    R15_HOLD = 2'd0,
    R15_PC   = 2'd1,
    R15_WR   = 2'd2
  } r15_src_e;

  // A general write to R15 (register-written branch)
  // outranks the fetch-stage pc load.
  function automatic r15_src_e r15_sel(
    input logic wr_hit,
    input logic pc_le
  );
    r15_src_e s;
    s = R15_HOLD;
    if (wr_hit)
      s = R15_WR;
    else if (pc_le)
      s = R15_PC;
    return s;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// register_file bus: write port, pc load, three read addresses
// and their data, plus pc_out. master = stage side, slave = regfile.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              wr_en;
  reg_addr_t         wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              pc_le;
  logic [DATA_W-1:0] pc_in;
  reg_addr_t         ra_addr;
  reg_addr_t         rb_addr;
  reg_addr_t         rd_addr;
  logic [DATA_W-1:0] pa;
  logic [DATA_W-1:0] pb;
  logic [DATA_W-1:0] pd;
  logic [DATA_W-1:0] pc_out;

  modport master (
    output wr_en, wr_addr, wr_data,
    output pc_le, pc_in,
    output ra_addr, rb_addr, rd_addr,
    input  pa, pb, pd, pc_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  pc_le, pc_in,
    input  ra_addr, rb_addr, rd_addr,
    output pa, pb, pd, pc_out
  );

endinterface

// File: rtl/register_file_binary_decoder.sv
// binary_decoder: sel (IN_W bits) -> onehot (2**IN_W bits),
// exactly one output line high for every select value.
module binary_decoder #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 1 << IN_W
) (
  input  logic [IN_W-1:0]  sel,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/register_file.sv
// register_file: 16 x DATA_W registers, one write port, pc path to R15,
// three combinational read ports (pa/pb/pd) and pc_out; clk, reset async-high.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  register_file_if.slave  rf
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] ld;
  logic [DATA_W-1:0]   r15_d;
  r15_src_e            r15_src;

  binary_decoder #(
    .IN_W  (REG_ADDR_W),
    .OUT_W (NUM_REGS)
  ) u_dec (
    .sel    (rf.wr_addr),
    .onehot (dec)
  );

  assign ld = dec & {NUM_REGS{rf.wr_en}};

  assign r15_src = r15_sel(ld[REG_PC], rf.pc_le);

  always_comb begin
    r15_d = regs[REG_PC];
    unique case (r15_src)
      R15_WR:   r15_d = rf.wr_data;
      R15_PC:   r15_d = rf.pc_in;
      default:  r15_d = regs[REG_PC];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++)
        if (ld[i])
          regs[i] <= rf.wr_data;
      regs[REG_PC] <= r15_d;
    end
  end

  logic [DATA_W-1:0] sa;
  logic [DATA_W-1:0] sb;
  logic [DATA_W-1:0] sd;

  assign sa = regs[rf.ra_addr];
  assign sb = regs[rf.rb_addr];
  assign sd = regs[rf.rd_addr];

  // Forwarding: the general write wins; a pc load is only
  // visible on R15 when no general write targets R15.
  function automatic logic [DATA_W-1:0] fwd(
    input reg_addr_t         a,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input reg_addr_t         wa,
    input logic [DATA_W-1:0] wd,
    input logic              ple,
    input logic [DATA_W-1:0] pci
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (we && (a == wa))
      v = wd;
    else if (ple && (a == REG_PC))
      v = pci;
    return v;
  endfunction

  if (BYPASS) begin : g_byp
    assign rf.pa = fwd(rf.ra_addr, sa, rf.wr_en,
                       rf.wr_addr, rf.wr_data,
                       rf.pc_le, rf.pc_in);
    assign rf.pb = fwd(rf.rb_addr, sb, rf.wr_en,
                       rf.wr_addr, rf.wr_data,
                       rf.pc_le, rf.pc_in);
    assign rf.pd = fwd(rf.rd_addr, sd, rf.wr_en,
                       rf.wr_addr, rf.wr_data,
                       rf.pc_le, rf.pc_in);
  end else begin : g_raw
    assign rf.pa = sa;
    assign rf.pb = sb;
    assign rf.pd = sd;
  end

  assign rf.pc_out = regs[REG_PC];

endmodule
